// File: rtl/shift_reg_piso_stream.sv
// shift_reg_piso_stream: parallel-in / serial-out stream shifter.
// A word is accepted with a valid/ready handshake and sent one bit per
// i_shift strobe, LSB or MSB first (MSB_FIRST). o_done pulses for one
// cycle after the last bit, and a new word may be accepted in that cycle.
// Optional feature macro: PISO_PARITY_EN -- appends the even parity of the
// accepted word as one extra bit after the data bits.
module shift_reg_piso_stream #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_shift,
  input  logic                         i_serial,
  output logic                         o_serial,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(WIDTH+2)-1:0]   o_bit_cnt
);

  localparam int CW = $clog2(WIDTH+2);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   shift_d;
  logic [CW-1:0]      cnt_q;
  logic               done_q;
  logic               data_bit;
`ifdef PISO_PARITY_EN
  logic               par_q;
`endif

  // Next shift-register value: move one place toward the output end and
  // fill the vacated end with the serial fill bit.
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], i_serial};
    end else begin
      shift_d = {i_serial, shift_q[WIDTH-1:1]};
    end
  end

  // FSM, shift register, bit counter and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A strobe arriving with the word is ignored: load only.
          if (i_valid) begin
            shift_q <= i_data;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
`ifdef PISO_PARITY_EN
            par_q   <= ^i_data;
`endif
          end
        end
        S_SHIFT: begin
          // i_valid is ignored here; the word in flight is never replaced.
          if (i_shift) begin
            shift_q <= shift_d;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Select the data bit at the output end of the register.
  always_comb begin
    if (MSB_FIRST) begin
      data_bit = shift_q[WIDTH-1];
    end else begin
      data_bit = shift_q[0];
    end
  end

  // Serial line: idle level outside a frame, parity bit in the final slot.
  always_comb begin
    o_serial = IDLE_LEVEL;
    if (state_q == S_SHIFT) begin
`ifdef PISO_PARITY_EN
      if (cnt_q == CW'(WIDTH)) begin
        o_serial = par_q;
      end else begin
        o_serial = data_bit;
      end
`else
      o_serial = data_bit;
`endif
    end else begin
      o_serial = IDLE_LEVEL;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q == S_SHIFT);
  assign o_done    = done_q;
  assign o_bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_reg_piso_stream.sv
// Directed bench for shift_reg_piso_stream: one LSB-first instance and one
// MSB-first instance (WIDTH=8, IDLE_LEVEL=1) sharing clock and reset.
module tb_shift_reg_piso_stream;

`ifdef PISO_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk;
  logic       rst;
  logic       valid_a, shift_a, ser_in_a;
  logic [7:0] data_a;
  logic       ready_a, serial_a, busy_a, done_a;
  logic [3:0] cnt_a;
  logic       valid_b, shift_b, ser_in_b;
  logic [7:0] data_b;
  logic       ready_b, serial_b, busy_b, done_b;
  logic [3:0] cnt_b;

  int n_chk;
  int n_pass;

  shift_reg_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .i_clk(clk), .i_reset(rst), .i_valid(valid_a), .o_ready(ready_a),
    .i_data(data_a), .i_shift(shift_a), .i_serial(ser_in_a),
    .o_serial(serial_a), .o_busy(busy_a), .o_done(done_a), .o_bit_cnt(cnt_a)
  );

  shift_reg_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .i_clk(clk), .i_reset(rst), .i_valid(valid_b), .o_ready(ready_b),
    .i_data(data_b), .i_shift(shift_b), .i_serial(ser_in_b),
    .o_serial(serial_b), .o_busy(busy_b), .o_done(done_b), .o_bit_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one LSB-first frame that has just been accepted; checks every bit,
  // the bit index, and the done cycle. Holds i_valid/i_data at the given
  // values throughout to show they are ignored.
  task automatic frame_a(input logic [7:0] w, input logic hold_v, input logic [7:0] other);
    logic exp_bit;
    valid_a = hold_v;
    data_a  = other;
    shift_a = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_bit = (i < 8) ? w[i] : ^w;
      chk("a_bit",   {31'd0, serial_a}, {31'd0, exp_bit});
      chk("a_cnt",   {28'd0, cnt_a},    32'(i));
      chk("a_busy",  {31'd0, busy_a},   32'd1);
      chk("a_ready", {31'd0, ready_a},  32'd0);
      chk("a_done0", {31'd0, done_a},   32'd0);
      tick();
    end
    chk("a_done",     {31'd0, done_a},   32'd1);
    chk("a_rdy_done", {31'd0, ready_a},  32'd1);
    chk("a_idle_lvl", {31'd0, serial_a}, 32'd1);
  endtask

  initial begin
    logic [7:0] wb;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    valid_a = 1'b0; shift_a = 1'b0; ser_in_a = 1'b0; data_a = 8'h00;
    valid_b = 1'b0; shift_b = 1'b0; ser_in_b = 1'b0; data_b = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready",  {31'd0, ready_a},  32'd1);
    chk("rst_busy",   {31'd0, busy_a},   32'd0);
    chk("rst_serial", {31'd0, serial_a}, 32'd1);
    chk("rst_done",   {31'd0, done_a},   32'd0);
    chk("rst_cnt",    {28'd0, cnt_a},    32'd0);
    chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
    chk("rst_serial_b", {31'd0, serial_b}, 32'd1);

    // A5 LSB first, strobe every cycle: 1,0,1,0,0,1,0,1; i_data changed after accept
    valid_a = 1'b1; data_a = 8'hA5;
    tick();
    frame_a(8'hA5, 1'b0, 8'h00);
    tick();   // i_shift still high in IDLE: ignored
    chk("a5_done_once", {31'd0, done_a},   32'd0);
    chk("a5_idle_busy", {31'd0, busy_a},   32'd0);
    chk("a5_idle_ser",  {31'd0, serial_a}, 32'd1);

    // i_valid and i_shift together in IDLE: load only, LSB (0) first
    valid_a = 1'b1; data_a = 8'h02; shift_a = 1'b1;
    tick();
    chk("vs_cnt",  {28'd0, cnt_a},    32'd0);
    chk("vs_bit0", {31'd0, serial_a}, 32'd0);
    frame_a(8'h02, 1'b0, 8'h00);
    shift_a = 1'b0;
    tick();

    // 3C with FF held on i_valid: FF accepted only in the done cycle, zero gap
    valid_a = 1'b1; data_a = 8'h3C;
    tick();
    frame_a(8'h3C, 1'b1, 8'hFF);
    tick();   // accept of FF in the done cycle
    chk("b2b_busy", {31'd0, busy_a}, 32'd1);
    chk("b2b_done", {31'd0, done_a}, 32'd0);
    frame_a(8'hFF, 1'b0, 8'h00);
    shift_a = 1'b0;
    tick();

    // Reset after 3 shifts of F0: abort, no done pulse
    valid_a = 1'b1; data_a = 8'hF0;
    tick();
    valid_a = 1'b0; shift_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("f0_bit", {31'd0, serial_a}, 32'd0);
      tick();
    end
    chk("f0_cnt3", {28'd0, cnt_a}, 32'd3);
    rst = 1'b1; valid_a = 1'b1;
    tick();
    rst = 1'b0; valid_a = 1'b0; shift_a = 1'b0;
    chk("ab_busy",  {31'd0, busy_a},   32'd0);
    chk("ab_ready", {31'd0, ready_a},  32'd1);
    chk("ab_ser",   {31'd0, serial_a}, 32'd1);
    chk("ab_done",  {31'd0, done_a},   32'd0);
    chk("ab_cnt",   {28'd0, cnt_a},    32'd0);
    tick();
    chk("ab_done2", {31'd0, done_a},   32'd0);

    // 07: data 1,1,1,0,0,0,0,0 (+ parity 1 when enabled)
    valid_a = 1'b1; data_a = 8'h07;
    tick();
    frame_a(8'h07, 1'b0, 8'h00);
    shift_a = 1'b0;
    tick();

    // MSB first A5, strobe every 4th cycle: each bit held 4 cycles
    wb = 8'hA5;
    valid_b = 1'b1; data_b = wb;
    tick();
    valid_b = 1'b0; data_b = 8'h00;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        chk("m_bit", {31'd0, serial_b}, {31'd0, (i < 8) ? wb[7-i] : ^wb});
        chk("m_cnt", {28'd0, cnt_b}, 32'(i));
        shift_b = (k == 3);
        tick();
      end
    end
    shift_b = 1'b0;
    chk("m_done",  {31'd0, done_b},   32'd1);
    chk("m_ready", {31'd0, ready_b},  32'd1);
    tick();
    chk("m_done_once", {31'd0, done_b},   32'd0);
    chk("m_idle_ser",  {31'd0, serial_b}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso_stream.md
SHIFT_REG_PISO_STREAM -- requirements
Module: shift_reg_piso_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the data word width in bits (minimum 2).
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 transmits the LSB first, 1 transmits the MSB first.
REQ-003 SHALL have parameter IDLE_LEVEL, default 1'b1, which is the o_serial level when no frame is in progress.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1 bit: the word on i_data is offered for transmission.
REQ-007 SHALL have port o_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port i_data, input, WIDTH bits: the parallel word, sampled on accept.
REQ-009 SHALL have port i_shift, input, 1 bit: shift strobe (e.g. baud tick), one bit advanced per strobe.
REQ-010 SHALL have port i_serial, input, 1 bit: serial fill bit, shifted into the vacated end.
REQ-011 SHALL have port o_serial, output, 1 bit: the current serial output bit.
REQ-012 SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-014 SHALL have port o_bit_cnt, output, $clog2(WIDTH+2) bits: the index of the bit currently on o_serial.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-016 The FSM SHALL drive o_ready=1 exactly when in IDLE, and o_busy=1 exactly when in SHIFT.
REQ-017 Accept SHALL occur when i_valid && o_ready at a clock edge; at that edge the shift register loads i_data, o_bit_cnt clears to 0, and the FSM enters SHIFT.
REQ-018 In SHIFT, o_serial SHALL equal r_shift[0] when MSB_FIRST=0 and r_shift[WIDTH-1] when MSB_FIRST=1; the first data bit is valid the cycle after accept.
REQ-019 In IDLE, o_serial SHALL equal IDLE_LEVEL.
REQ-020 On i_shift in SHIFT, the register SHALL shift one position toward the output end, fill the vacated end with i_serial, and increment o_bit_cnt.
REQ-021 The frame length SHALL be N=WIDTH bits, or WIDTH+1 bits with the parity option (REQ-033).
REQ-022 An i_shift while o_bit_cnt==N-1 SHALL end the frame: the FSM returns to IDLE and o_done=1 for exactly the next cycle.
REQ-023 The last bit SHALL be held on o_serial until that terminating strobe.
REQ-024 Back-to-back frames: o_ready SHALL be 1 in the o_done cycle; an accept in that cycle restarts SHIFT with no extra idle cycle.
REQ-025 i_shift in IDLE SHALL be ignored.
REQ-026 i_valid in SHIFT SHALL be ignored and the word SHALL NOT be latched.
REQ-027 i_valid and i_shift in the same IDLE cycle SHALL cause the load only; no bit is consumed.
REQ-028 i_data SHALL be sampled only at the accept edge; later changes to i_data SHALL have no effect.
REQ-029 Consecutive i_shift strobes on every cycle SHALL be supported, giving one bit per clock.

Reset
REQ-030 When i_reset=1 at an edge, reset SHALL take priority over all other inputs: FSM=IDLE, r_shift=0, o_bit_cnt=0, o_done=0.
REQ-031 After reset, the outputs SHALL be o_ready=1, o_busy=0, o_serial=IDLE_LEVEL.
REQ-032 Reset during SHIFT SHALL abort the frame with no o_done pulse.

Configuration
REQ-033 With macro PISO_PARITY_EN defined, parity SHALL be appended: the even parity of the accepted word (XOR of i_data) is latched at accept and sent as bit index WIDTH after the data bits, giving N=WIDTH+1.
REQ-034 With PISO_PARITY_EN undefined, there SHALL be no parity logic and N=WIDTH.

Verification
REQ-035 Scenario: WIDTH=8, MSB_FIRST=0, accept 8'hA5, i_shift every cycle -> o_serial 1,0,1,0,0,1,0,1, then o_done pulses once, then o_serial=1 (IDLE_LEVEL).
REQ-036 Scenario: MSB_FIRST=1, accept 8'hA5, i_shift every 4th cycle -> o_serial 1,0,1,0,0,1,0,1, each bit held 4 cycles.
REQ-037 Scenario: accept 8'h3C, i_valid held with 8'hFF during the frame -> 8'h3C bits are sent, 8'hFF is accepted only in the o_done cycle, and the second frame follows with zero gap.
REQ-038 Scenario: i_reset asserted after 3 shifts of 8'hF0 -> next cycle o_busy=0, o_serial=IDLE_LEVEL, and no o_done pulse.
REQ-039 Scenario: PISO_PARITY_EN defined, accept 8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1 (parity=1), then o_done.
REQ-040 Scenario: i_valid and i_shift high in the same IDLE cycle -> o_bit_cnt=0 and the first bit is still the data LSB.
